seq_mult_gen: RTL and testbench



---
 rtl/seq_mult_gen.sv | 117 +++++++++++
 tb/tb_seq_mult_gen.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_gen.sv
// Sequential N x N multiplier: shift-add for unsigned operands, radix-2 Booth for signed.
// One multiplier bit is retired per CALC cycle; the product is held in DONE until ack.
module seq_mult_gen #(
    parameter int N         = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [N-1:0]   mcand,
    input  logic [N-1:0]   mlier,
    input  logic           ack,
    output logic           ready,
    output logic           busy,
    output logic           valid,
    output logic [2*N-1:0] prod
);

    // Handshake: start is taken only on an edge where ready=1 (IDLE); valid=1 holds
    // prod steady until the edge where ack=1, which returns the block to IDLE.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     mcand_q;
    logic             mode_q;
    logic [N:0]       acc_q;     // upper half plus one guard bit for the -2^(N-1) squared case
    logic [N-1:0]     mq_q;
    logic             qprev_q;
    logic [CW-1:0]    cnt_q;
    logic [2*N-1:0]   prod_q;

    logic [N:0]       mcand_ext;
    logic [N:0]       sum;
    logic             shift_in;

    assign mcand_ext = mode_q ? {mcand_q[N-1], mcand_q} : {1'b0, mcand_q};

    always_comb begin
        sum = acc_q;
        if (mode_q) begin
            case ({mq_q[0], qprev_q})
                2'b10:   sum = acc_q - mcand_ext;
                2'b01:   sum = acc_q + mcand_ext;
                default: sum = acc_q;
            endcase
        end else if (mq_q[0]) begin
            sum = acc_q + mcand_ext;
        end
    end

    assign shift_in = mode_q & sum[N];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_q <= '0;
            mode_q  <= 1'b0;
            acc_q   <= '0;
            mq_q    <= '0;
            qprev_q <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mcand_q <= mcand;
                        mode_q  <= signed_mode & SIGNED_EN;
                        acc_q   <= '0;
                        mq_q    <= mlier;
                        qprev_q <= 1'b0;
                        cnt_q   <= CW'(N);
                    end
                end
                CALC: begin
                    if (cnt_q != '0) begin
                        acc_q   <= {shift_in, sum[N:1]};
                        mq_q    <= {sum[0], mq_q[N-1:1]};
                        qprev_q <= mq_q[0];
                        cnt_q   <= cnt_q - CW'(1);
                    end else begin
                        // All N bits retired: the guard bit is dropped, the low 2N bits are exact.
                        prod_q <= {acc_q[N-1:0], mq_q};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == CALC);
    assign valid = (state_q == DONE);
    assign prod  = prod_q;

endmodule

// File: tb/tb_seq_mult_gen.sv
// Bench for seq_mult_gen: three instances (N=4, 8, 32) share one stimulus bus; a queue
// scoreboard checks product, latency and hold stability whenever the selected instance is valid.
module tb_seq_mult_gen;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start_c = 1'b0;
    logic         ack_man = 1'b0;
    logic         ack_auto = 1'b0;
    logic         auto_ack_en = 1'b0;
    logic         signed_mode = 1'b0;
    logic [63:0]  mcand_c = '0;
    logic [63:0]  mlier_c = '0;
    logic [1:0]   sel = 2'd1;

    logic         ready4, busy4, valid4;
    logic [7:0]   prod4;
    logic         ready8, busy8, valid8;
    logic [15:0]  prod8;
    logic         ready32, busy32, valid32;
    logic [63:0]  prod32;

    logic         ready_m, busy_m, valid_m;
    logic [127:0] prod_m;
    logic         ack_c;

    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    int           valid_seen = 0;

    logic [127:0] exp_q[$];
    int           lat_q[$];
    int           n_q[$];

    assign ack_c = ack_man | ack_auto;

    seq_mult_gen #(.N(4), .SIGNED_EN(1'b1)) dut4 (
        .clock(clock), .reset(reset), .start(start_c && sel == 2'd0),
        .signed_mode(signed_mode), .mcand(mcand_c[3:0]), .mlier(mlier_c[3:0]),
        .ack(ack_c && sel == 2'd0), .ready(ready4), .busy(busy4), .valid(valid4), .prod(prod4)
    );

    seq_mult_gen #(.N(8), .SIGNED_EN(1'b1)) dut8 (
        .clock(clock), .reset(reset), .start(start_c && sel == 2'd1),
        .signed_mode(signed_mode), .mcand(mcand_c[7:0]), .mlier(mlier_c[7:0]),
        .ack(ack_c && sel == 2'd1), .ready(ready8), .busy(busy8), .valid(valid8), .prod(prod8)
    );

    seq_mult_gen #(.N(32), .SIGNED_EN(1'b1)) dut32 (
        .clock(clock), .reset(reset), .start(start_c && sel == 2'd2),
        .signed_mode(signed_mode), .mcand(mcand_c[31:0]), .mlier(mlier_c[31:0]),
        .ack(ack_c && sel == 2'd2), .ready(ready32), .busy(busy32), .valid(valid32), .prod(prod32)
    );

    always_comb begin
        ready_m = ready8;
        busy_m  = busy8;
        valid_m = valid8;
        prod_m  = {112'b0, prod8};
        case (sel)
            2'd0: begin
                ready_m = ready4; busy_m = busy4; valid_m = valid4; prod_m = {120'b0, prod4};
            end
            2'd2: begin
                ready_m = ready32; busy_m = busy32; valid_m = valid32; prod_m = {64'b0, prod32};
            end
            default: ;
        endcase
    end

    // clock / cycle counter
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic int n_of(input logic [1:0] s);
        case (s)
            2'd0:    return 4;
            2'd1:    return 8;
            default: return 32;
        endcase
    endfunction

    // Reference product: extend both operands to 128 bits, multiply, keep the low 2n bits.
    function automatic logic [127:0] ref_prod(input int n, input logic sm,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ae, be, p;
        for (int i = 0; i < 128; i++) begin
            ae[i] = (i < n) ? a[i] : (sm & a[n-1]);
            be[i] = (i < n) ? b[i] : (sm & b[n-1]);
        end
        p = ae * be;
        for (int i = 2 * n; i < 128; i++) p[i] = 1'b0;
        return p;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || !ready_m) && w < 500) begin
            @(negedge clock);
            w++;
        end
        if (exp_q.size() != 0 || !ready_m) timeout("drain");
    endtask

    // driver: one start pulse, expected result pushed at the moment start is presented
    task automatic issue(input logic [1:0] s, input logic sm, input logic [63:0] a,
                         input logic [63:0] b, input logic [127:0] e);
        int w = 0;
        if (s != sel) drain();
        sel = s;
        @(negedge clock);
        while (!ready_m && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!ready_m) timeout("wait_ready");
        signed_mode = sm;
        mcand_c     = a;
        mlier_c     = b;
        start_c     = 1'b1;
        exp_q.push_back(e);
        lat_q.push_back(cyc + 1);
        n_q.push_back(n_of(s));
        @(negedge clock);
        start_c     = 1'b0;
        mcand_c     = {$urandom, $urandom};
        mlier_c     = {$urandom, $urandom};
        signed_mode = 1'(($urandom_range(0, 1)));
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!valid_m && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!valid_m) timeout("wait_valid");
    endtask

    // monitor / scoreboard
    initial begin
        logic [127:0] e;
        logic [127:0] held;
        logic         valid_prev;
        int           c0, n, ack_wait;
        held = '0;
        valid_prev = 1'b0;
        ack_wait = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                valid_prev = 1'b0;
                ack_auto   = 1'b0;
            end else begin
                if (valid_m) begin
                    if (!valid_prev) begin
                        valid_seen++;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_valid: got prod %0h with nothing expected", prod_m);
                        end else begin
                            e  = exp_q.pop_front();
                            c0 = lat_q.pop_front();
                            n  = n_q.pop_front();
                            check("prod", prod_m, e);
                            check("latency", 128'(cyc - c0), 128'(n + 1));
                        end
                        held     = prod_m;
                        ack_wait = $urandom_range(0, 5);
                    end else begin
                        check("prod_stable", prod_m, held);
                    end
                    if (auto_ack_en && ack_wait == 0) begin
                        ack_auto = 1'b1;
                    end else begin
                        ack_auto = 1'b0;
                        if (ack_wait > 0) ack_wait--;
                    end
                end else begin
                    ack_auto = 1'b0;
                end
                valid_prev = valid_m;
            end
        end
    end

    // main sequence
    initial begin
        int seen0;
        logic [1:0]  s;
        logic        sm;
        logic [63:0] a, b;

        repeat (3) @(negedge clock);
        check("rst_ready8", 128'(ready8), 128'(1));
        check("rst_busy8", 128'(busy8), 128'(0));
        check("rst_valid8", 128'(valid8), 128'(0));
        check("rst_prod8", 128'(prod8), 128'(0));
        check("rst_ready32", 128'(ready32), 128'(1));
        check("rst_prod4", 128'(prod4), 128'(0));
        reset = 1'b0;

        // unsigned all-ones held until a late manual ack
        auto_ack_en = 1'b0;
        issue(2'd1, 1'b0, 64'hFF, 64'hFF, 128'hFE01);
        wait_valid();
        repeat (5) @(negedge clock);
        check("hold_valid", 128'(valid_m), 128'(1));
        check("hold_ready", 128'(ready_m), 128'(0));
        ack_man = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        check("ack_ready", 128'(ready_m), 128'(1));
        check("ack_valid", 128'(valid_m), 128'(0));

        // start together with ack in DONE: ack wins, start not queued
        issue(2'd1, 1'b1, 64'h80, 64'h7F, 128'hC080);
        wait_valid();
        ack_man = 1'b1;
        start_c = 1'b1;
        @(negedge clock);
        ack_man = 1'b0;
        start_c = 1'b0;
        check("ackstart_ready", 128'(ready_m), 128'(1));
        check("ackstart_valid", 128'(valid_m), 128'(0));
        @(negedge clock);
        check("ackstart_noqueue", 128'(busy_m), 128'(0));

        auto_ack_en = 1'b1;
        issue(2'd1, 1'b1, 64'h80, 64'h80, 128'h4000);
        issue(2'd1, 1'b0, 64'h80, 64'h80, 128'h4000);
        issue(2'd1, 1'b1, 64'hFF, 64'hFF, 128'h0001);
        issue(2'd1, 1'b1, 64'h7F, 64'h7F, 128'h3F01);
        issue(2'd1, 1'b0, 64'h00, 64'hAB, 128'h0000);
        issue(2'd1, 1'b1, 64'h05, 64'hFD, 128'hFFF1);

        // start pulses during CALC are ignored
        issue(2'd1, 1'b0, 64'h5A, 64'h3C, 128'h1518);
        for (int i = 0; i < 3; i++) begin
            start_c = 1'b1;
            mcand_c = {$urandom, $urandom};
            check("calc_not_ready", 128'(ready_m), 128'(0));
            @(negedge clock);
        end
        start_c = 1'b0;
        drain();

        // reset four cycles into CALC aborts the operation
        issue(2'd1, 1'b0, 64'h12, 64'h34, 128'h03A8);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        lat_q.delete();
        n_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("abort_ready", 128'(ready_m), 128'(1));
        check("abort_busy", 128'(busy_m), 128'(0));
        check("abort_prod", prod_m, 128'h0);
        seen0 = valid_seen;
        repeat (20) @(negedge clock);
        check("abort_no_valid", 128'(valid_seen), 128'(seen0));

        // N=32 and N=4 directed vectors
        issue(2'd2, 1'b1, 64'hFFFF_FFFD, 64'h7, 128'hFFFF_FFFF_FFFF_FFEB);
        issue(2'd2, 1'b0, 64'hFFFF_FFFD, 64'h7, 128'h0000_0006_FFFF_FFEB);
        issue(2'd2, 1'b1, 64'h8000_0000, 64'h8000_0000, 128'h4000_0000_0000_0000);
        issue(2'd2, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001);
        issue(2'd0, 1'b1, 64'h8, 64'h8, 128'h40);
        issue(2'd0, 1'b1, 64'h8, 64'h7, 128'hC8);
        issue(2'd0, 1'b0, 64'hF, 64'hF, 128'hE1);
        issue(2'd0, 1'b1, 64'hF, 64'h3, 128'hFD);

        // random regression across widths and modes
        for (int i = 0; i < 24; i++) begin
            s  = 2'($urandom_range(0, 2));
            sm = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            issue(s, sm, a, b, ref_prod(n_of(s), sm, a, b));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
